metaball_unit: RTL and testbench
================================

METABALL_UNIT -- requirements
Module: metaball_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IX, 20: initial centre x.
- IY, 20: initial centre y.
- RD, 10: radius, legal range 1..255.
- IX_DIR, 1: initial x step, +1 or -1.
- IY_DIR, 1: initial y step, +1 or -1.
- D_WIDTH, 180: display width in pixels.
- D_HEIGHT, 90: display height in pixels.
- WAIT, 4: number of i_animate pulses per move, 1 or more.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1: the single clock.
- i_rst, in, 1: asynchronous, active-high reset.
- i_x, in, 32: signed pixel x to evaluate.
- i_y, in, 32: signed pixel y to evaluate.
- i_animate, in, 1: frame-tick pulse.
- o_f, out, 32: field value, unsigned fixed point with 15 fractional bits (Q16.15, MSB always 0).
- o_complete, out, 1: one-cycle strobe meaning o_f has just been updated.

Function
REQ-003 Field value SHALL be f = floor(RD*RD*2^15 / d2), where d2 = (i_x-cx)^2 + (i_y-cy)^2, computed in 32-bit signed arithmetic.
REQ-004 When d2 = 0, f SHALL saturate to 0x7FFFFFFF.
REQ-005 The computation SHALL run as a free-running FSM: LOAD, then DIV, then DONE, then back to LOAD.
REQ-006 In LOAD (1 cycle), the block SHALL sample i_x, i_y, cx and cy, and compute d2.
REQ-007 DIV SHALL be a restoring divider producing 1 quotient bit per cycle, for exactly 32 cycles, MSB first.
REQ-008 In DONE (1 cycle), o_f SHALL be loaded with the quotient and o_complete SHALL be 1.
REQ-009 o_complete SHALL be 0 in every other state.
REQ-010 Result period SHALL be 34 cycles: o_complete is high on cycle 34 counting the first LOAD as cycle 1, then every 34 cycles after that.
REQ-011 o_f SHALL hold its value between DONE cycles.
REQ-012 i_x and i_y SHALL be sampled only in LOAD; changes during DIV SHALL not affect the current result.
REQ-013 Animation: a counter SHALL count i_animate cycles that are high. On the WAIT-th pulse the counter clears to 0 and the centre moves one step.
REQ-014 Each move SHALL update x first: if cx+dx < RD or cx+dx > D_WIDTH-1-RD, dx negates and cx moves by the new dx; otherwise cx moves by dx.
REQ-015 The same bounce rule SHALL apply to y, using D_HEIGHT-1-RD.
REQ-016 Centre moves SHALL be independent of the FSM. A move coinciding with LOAD SHALL be seen by LOAD as the pre-move centre, because the update is registered.
REQ-017 i_animate held high for N cycles SHALL count as N pulses.
REQ-018 cx and cy SHALL be 16-bit signed registers; dx and dy SHALL be 2-bit signed.

Reset
REQ-019 While i_rst is high, regardless of clock, the block SHALL hold:
- state = LOAD
- o_f = 0
- o_complete = 0
- cx = IX, cy = IY
- dx = IX_DIR, dy = IY_DIR
- animate counter = 0
- divider registers = 0
REQ-020 Reset asserted during DIV SHALL abort the division with no o_complete pulse. After release, the first o_complete SHALL occur 34 cycles after the first LOAD.

Verification
REQ-021 The bench SHALL cover these scenarios (defaults unless stated):
- Reset: o_f=0, o_complete=0. After release, i_x=20, i_y=20: o_complete high on cycle 34, o_f=0x7FFFFFFF.
- i_x=30, i_y=20 (d2=100=RD^2): o_f=0x00008000 (1.0).
- i_x=40, i_y=20 (d2=400): o_f=0x00002000 (0.25).
- i_x=23, i_y=24 (d2=25): o_f=0x00020000 (4.0).
- i_x changed mid-DIV: result still reflects the value sampled at LOAD; o_complete period stays 34 cycles.
- 4 i_animate pulses: cx=21. IX=169, RD=10, D_WIDTH=180, WAIT=1, one pulse: dx becomes -1, cx=168. Reset asserted mid-DIV: no o_complete, all reset values restored.

Source files
------------

// File: rtl/metaball_unit.sv
// Metaball field evaluator: f = RD^2 * 2^15 / d2 via a 32-cycle restoring divider,
// with a centre that bounces around the display on every WAIT-th i_animate pulse.
module metaball_unit #(
    parameter int IX       = 20,
    parameter int IY       = 20,
    parameter int RD       = 10,
    parameter int IX_DIR   = 1,
    parameter int IY_DIR   = 1,
    parameter int D_WIDTH  = 180,
    parameter int D_HEIGHT = 90,
    parameter int WAIT     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  logic        i_animate,
    output logic [31:0] o_f,
    output logic        o_complete
);

    typedef enum logic [1:0] {LOAD = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

    localparam logic [31:0] DIVIDEND = 32'(RD * RD * 32768);
    localparam int XMAX = D_WIDTH - 1 - RD;
    localparam int YMAX = D_HEIGHT - 1 - RD;
    localparam int CW   = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);

    state_t state, state_nx;

    logic signed [15:0] cx, cy, cx_nx, cy_nx;
    logic signed [1:0]  dx, dy, dx_nx, dy_nx;
    logic [CW-1:0]      anim_cnt;
    int                 px, py;

    logic [4:0]  bit_cnt;
    logic [31:0] rem, quo, divisor;
    logic        zero_d;
    logic [31:0] ex, ey, d2;
    logic [32:0] trial, diff;
    logic [31:0] rem_nx, quo_nx;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= LOAD;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = DIV;
            DIV:     state_nx = (bit_cnt == 5'd31) ? DONE : DIV;
            DONE:    state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        o_complete = (state == DONE);
    end

    // Distance squared (mod 2^32) and one restoring-division step
    always_comb begin
        ex     = i_x - {{16{cx[15]}}, cx};
        ey     = i_y - {{16{cy[15]}}, cy};
        d2     = ex * ex + ey * ey;
        trial  = {rem, quo[31]};
        diff   = trial - {1'b0, divisor};
        rem_nx = trial[31:0];
        quo_nx = {quo[30:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            rem_nx = diff[31:0];
            quo_nx = {quo[30:0], 1'b1};
        end
    end

    // o_f is written on the edge that enters DONE so it is already valid while o_complete is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            zero_d  <= 1'b0;
            bit_cnt <= '0;
            o_f     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    rem     <= '0;
                    quo     <= DIVIDEND;
                    divisor <= d2;
                    zero_d  <= (d2 == '0);
                    bit_cnt <= '0;
                end
                DIV: begin
                    rem     <= rem_nx;
                    quo     <= quo_nx;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31)
                        o_f <= zero_d ? 32'h7FFF_FFFF : quo_nx;
                end
                default: ;
            endcase
        end
    end

    // Bounce: on overshoot the direction flips and the centre steps the new way
    always_comb begin
        px    = int'(cx) + int'(dx);
        py    = int'(cy) + int'(dy);
        dx_nx = dx;
        dy_nx = dy;
        cx_nx = 16'(px);
        cy_nx = 16'(py);
        if (px < RD || px > XMAX) begin
            dx_nx = -dx;
            cx_nx = 16'(int'(cx) - int'(dx));
        end
        if (py < RD || py > YMAX) begin
            dy_nx = -dy;
            cy_nx = 16'(int'(cy) - int'(dy));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cx       <= 16'(IX);
            cy       <= 16'(IY);
            dx       <= 2'(IX_DIR);
            dy       <= 2'(IY_DIR);
            anim_cnt <= '0;
        end else if (i_animate) begin
            if (anim_cnt == CNT_LAST) begin
                anim_cnt <= '0;
                cx       <= cx_nx;
                cy       <= cy_nx;
                dx       <= dx_nx;
                dy       <= dy_nx;
            end else begin
                anim_cnt <= anim_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_metaball_unit.sv
// Scoreboard bench for metaball_unit: two instances (default, and a right-edge bounce
// configuration) checked against a reference field and bounce model.
module tb_metaball_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, y1, x2, y2;
    logic        anim;
    logic [31:0] f1, f2;
    logic        c1, c2;

    always #5 clk = ~clk;

    metaball_unit u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_x(x1), .i_y(y1), .i_animate(anim),
        .o_f(f1), .o_complete(c1)
    );

    metaball_unit #(.IX(169), .RD(10), .D_WIDTH(180), .WAIT(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_x(x2), .i_y(y2), .i_animate(anim),
        .o_f(f2), .o_complete(c2)
    );

    localparam int RDV  = 10;
    localparam int XLIM = 169;
    localparam int YLIM = 79;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];

    int init_x[2] = '{20, 169};
    int wait_n[2] = '{4, 1};
    int m_cx[2], m_cy[2], m_dx[2], m_dy[2], m_cnt[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fexp(input int cx, input int cy,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ddx, ddy, d2;
        logic [63:0] num;
        ddx = x - 32'(cx);
        ddy = y - 32'(cy);
        d2  = ddx * ddx + ddy * ddy;
        if (d2 == 32'd0) return 32'h7FFF_FFFF;
        num = 64'(RDV * RDV) << 15;
        return 32'(num / {32'd0, d2});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cx[i]  = init_x[i];
            m_cy[i]  = 20;
            m_dx[i]  = 1;
            m_dy[i]  = 1;
            m_cnt[i] = 0;
        end
    endtask

    task automatic bounce(inout int c, inout int d, input int lim);
        if (c + d < RDV || c + d > lim) d = -d;
        c = c + d;
    endtask

    task automatic model_pulse();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]++;
            if (m_cnt[i] == wait_n[i]) begin
                m_cnt[i] = 0;
                bounce(m_cx[i], m_dx[i], XLIM);
                bounce(m_cy[i], m_dy[i], YLIM);
            end
        end
    endtask

    always @(negedge clk) begin
        if (c1) begin
            if (q1.size() == 0) check("dut1_spurious_complete", 32'(c1), 32'd0);
            else                check("dut1_f", f1, q1.pop_front());
        end
        if (c2) begin
            if (q2.size() == 0) check("dut2_spurious_complete", 32'(c2), 32'd0);
            else                check("dut2_f", f2, q2.pop_front());
        end
    end

    // Called on a negedge while the FSM is in LOAD; returns on the next such negedge.
    task automatic txn(input logic [31:0] ax, input logic [31:0] ay,
                       input logic [31:0] bx, input logic [31:0] by,
                       input bit mid, input int pulses);
        x1 = ax; y1 = ay; x2 = bx; y2 = by;
        q1.push_back(fexp(m_cx[0], m_cy[0], ax, ay));
        q2.push_back(fexp(m_cx[1], m_cy[1], bx, by));
        @(posedge clk);
        for (int k = 2; k <= 33; k++) begin
            @(negedge clk);
            anim = (k >= 10 && k < 10 + pulses);
            if (anim) model_pulse();
            if (mid && k == 6) begin
                x1 = ax + 32'd5;
                x2 = bx + 32'd5;
            end
            if (k == 33) begin
                check("no_early_complete1", 32'(c1), 32'd0);
                check("no_early_complete2", 32'(c2), 32'd0);
            end
            @(posedge clk);
        end
        anim = 1'b0;
        @(negedge clk);
        check("complete_cycle34_1", 32'(c1), 32'd1);
        check("complete_cycle34_2", 32'(c2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("complete_one_cycle1", 32'(c1), 32'd0);
        check("complete_one_cycle2", 32'(c2), 32'd0);
    endtask

    task automatic abort_div();
        x1 = 32'd45; y1 = 32'd33; x2 = 32'd150; y2 = 32'd40;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_f1", f1, 32'd0);
        check("abort_c1", 32'(c1), 32'd0);
        check("abort_f2", f2, 32'd0);
        check("abort_c2", 32'(c2), 32'd0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("abort_hold_c1", 32'(c1), 32'd0);
            check("abort_hold_f1", f1, 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        anim = 1'b0;
        x1 = 32'd20; y1 = 32'd20; x2 = 32'd169; y2 = 32'd20;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_f1", f1, 32'd0);
        check("reset_c1", 32'(c1), 32'd0);
        check("reset_f2", f2, 32'd0);
        check("reset_c2", 32'(c2), 32'd0);
        rst = 1'b0;

        txn(32'd20, 32'd20, 32'd169, 32'd20, 1'b0, 0);
        txn(32'd30, 32'd20, 32'd179, 32'd20, 1'b0, 0);
        txn(32'd40, 32'd20, 32'd189, 32'd20, 1'b0, 0);
        txn(32'd23, 32'd24, 32'd172, 32'd24, 1'b0, 0);
        txn(32'd30, 32'd20, 32'd179, 32'd20, 1'b1, 0);
        txn(32'd50, 32'd20, 32'd169, 32'd50, 1'b0, 4);
        txn(32'd21, 32'd21, 32'd165, 32'd24, 1'b0, 0);
        txn(32'd31, 32'd21, 32'd165, 32'd34, 1'b0, 0);

        abort_div();
        txn(32'd20, 32'd20, 32'd169, 32'd20, 1'b0, 0);

        for (int r = 0; r < 3; r++)
            txn($urandom_range(60), $urandom_range(60),
                32'd140 + $urandom_range(40), $urandom_range(60), 1'b0, 2);

        repeat (2) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
